// File: rtl/memu.sv
// memu: memory-access stage between EXEU and WBU, issuing single-beat load/store on dmem.
// Define MEMU_MISALIGN_CHK_EN to trap size-misaligned accesses instead of issuing them.
module memu #(
    parameter int unsigned SB_W = 141,
    parameter int unsigned AW   = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exe_to_mem_valid,
    output logic            mem_allow_in,
    output logic            mem_valid,
    output logic            mem_to_wb_valid,
    input  logic            wb_allow_in,
    input  logic            clear_pipline,
    input  logic [63:0]     exe_pc,
    input  logic [31:0]     exe_inst,
    input  logic [4:0]      exe_rd,
    input  logic            exe_rd_wen,
    input  logic [63:0]     exe_result,
    input  logic [63:0]     exe_rs2_data,
    input  logic [6:0]      exe_ld_type,
    input  logic [3:0]      exe_st_type,
    input  logic [SB_W-1:0] exe_sideband,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [AW-1:0]   dmem_addr,
    output logic            dmem_wen,
    output logic [7:0]      dmem_wstrb,
    output logic [63:0]     dmem_wdata,
    input  logic            dmem_resp_valid,
    input  logic [63:0]     dmem_rdata,
    output logic [63:0]     mem_pc,
    output logic [31:0]     mem_inst,
    output logic [4:0]      mem_rd,
    output logic            mem_rd_wen,
    output logic [SB_W-1:0] mem_sideband,
    output logic [63:0]     mem_result,
    output logic            mem_ex_misalign
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDrain} state_e;

    state_e          r_state;
    logic            r_valid;
    logic [63:0]     r_pc;
    logic [31:0]     r_inst;
    logic [4:0]      r_rd;
    logic            r_rd_wen;
    logic [SB_W-1:0] r_sb;
    logic [63:0]     r_result;
    logic [63:0]     r_rs2;
    logic [6:0]      r_ld_type;
    logic [3:0]      r_st_type;
    logic            r_misalign;

    logic            w_is_mem;
    logic            w_in_is_mem;
    logic            w_in_misalign;
    logic            w_ready_go;
    logic            w_allow_in;
    logic            w_latch;
    logic [63:0]     w_ld_shift;
    logic [63:0]     w_ld_data;
    logic [7:0]      w_strb_base;
    logic [63:0]     w_wdata;

    assign w_is_mem    = (|r_ld_type) | (|r_st_type);
    assign w_in_is_mem = (|exe_ld_type) | (|exe_st_type);
    assign w_ready_go  = (r_state == StDone) | ((r_state == StIdle) & ~w_is_mem);
    assign w_allow_in  = (r_state != StDrain) & (~r_valid | (w_ready_go & wb_allow_in));
    // A flushed cycle accepts nothing, so the FSM never starts a killed instruction.
    assign w_latch     = exe_to_mem_valid & w_allow_in & ~clear_pipline;

`ifdef MEMU_MISALIGN_CHK_EN
    logic w_in_half, w_in_word, w_in_dword;
    assign w_in_half     = exe_ld_type[1] | exe_ld_type[5] | exe_st_type[1];
    assign w_in_word     = exe_ld_type[2] | exe_ld_type[6] | exe_st_type[2];
    assign w_in_dword    = exe_ld_type[3] | exe_st_type[3];
    assign w_in_misalign = (w_in_half & exe_result[0]) | (w_in_word & (|exe_result[1:0]))
                         | (w_in_dword & (|exe_result[2:0]));
`else
    assign w_in_misalign = 1'b0;
`endif

    always_comb begin
        w_ld_shift = dmem_rdata >> {r_result[2:0], 3'b000};
        w_ld_data  = w_ld_shift;
        unique case (1'b1)
            r_ld_type[0]: w_ld_data = {{56{w_ld_shift[7]}}, w_ld_shift[7:0]};
            r_ld_type[1]: w_ld_data = {{48{w_ld_shift[15]}}, w_ld_shift[15:0]};
            r_ld_type[2]: w_ld_data = {{32{w_ld_shift[31]}}, w_ld_shift[31:0]};
            r_ld_type[4]: w_ld_data = {56'd0, w_ld_shift[7:0]};
            r_ld_type[5]: w_ld_data = {48'd0, w_ld_shift[15:0]};
            r_ld_type[6]: w_ld_data = {32'd0, w_ld_shift[31:0]};
            default:      w_ld_data = w_ld_shift;
        endcase
    end

    always_comb begin
        w_strb_base = 8'h00;
        w_wdata     = r_rs2;
        unique case (1'b1)
            r_st_type[0]: begin w_strb_base = 8'h01; w_wdata = {8{r_rs2[7:0]}};  end
            r_st_type[1]: begin w_strb_base = 8'h03; w_wdata = {4{r_rs2[15:0]}}; end
            r_st_type[2]: begin w_strb_base = 8'h0F; w_wdata = {2{r_rs2[31:0]}}; end
            r_st_type[3]: begin w_strb_base = 8'hFF; w_wdata = r_rs2;            end
            default:      begin w_strb_base = 8'h00; w_wdata = r_rs2;            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_inst     <= '0;
            r_rd       <= '0;
            r_rd_wen   <= 1'b0;
            r_sb       <= '0;
            r_result   <= '0;
            r_rs2      <= '0;
            r_ld_type  <= '0;
            r_st_type  <= '0;
            r_misalign <= 1'b0;
        end else begin
            if (clear_pipline) begin
                r_valid <= 1'b0;
            end else if (w_allow_in) begin
                r_valid <= exe_to_mem_valid;
            end
            if (w_latch) begin
                r_pc       <= exe_pc;
                r_inst     <= exe_inst;
                r_rd       <= exe_rd;
                r_rd_wen   <= exe_rd_wen;
                r_sb       <= exe_sideband;
                r_result   <= exe_result;
                r_rs2      <= exe_rs2_data;
                r_ld_type  <= exe_ld_type;
                r_st_type  <= exe_st_type;
                r_misalign <= w_in_misalign;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_latch && w_in_is_mem) r_state <= w_in_misalign ? StDone : StReq;
                end
                StReq: begin
                    if (clear_pipline) r_state <= dmem_req_ready ? StDrain : StIdle;
                    else if (dmem_req_ready) r_state <= StWait;
                end
                StWait: begin
                    // A response coinciding with the flush leaves nothing to drain.
                    if (clear_pipline) begin
                        r_state <= dmem_resp_valid ? StIdle : StDrain;
                    end else if (dmem_resp_valid) begin
                        if (|r_ld_type) r_result <= w_ld_data;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    if (clear_pipline) begin
                        r_state <= StIdle;
                    end else if (w_allow_in) begin
                        if (w_latch && w_in_is_mem) r_state <= w_in_misalign ? StDone : StReq;
                        else r_state <= StIdle;
                    end
                end
                StDrain: begin
                    if (dmem_resp_valid) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign mem_allow_in    = w_allow_in;
    assign mem_valid       = r_valid;
    assign mem_to_wb_valid = r_valid & w_ready_go & ~clear_pipline;
    assign dmem_req_valid  = (r_state == StReq);
    assign dmem_addr       = {r_result[AW-1:3], 3'b000};
    assign dmem_wen        = |r_st_type;
    assign dmem_wstrb      = w_strb_base << r_result[2:0];
    assign dmem_wdata      = w_wdata;
    assign mem_pc          = r_pc;
    assign mem_inst        = r_inst;
    assign mem_rd          = r_rd;
    assign mem_rd_wen      = r_rd_wen;
    assign mem_sideband    = r_sb;
    assign mem_result      = r_result;
    assign mem_ex_misalign = r_misalign;

endmodule

// File: tb/tb_memu.sv
// tb_memu: directed self-checking bench for the memu memory-access stage.
module tb_memu;

    localparam int unsigned SB_W = 141;
    localparam int unsigned AW   = 64;

    localparam logic [6:0] LB  = 7'b0000001;
    localparam logic [6:0] LH  = 7'b0000010;
    localparam logic [6:0] LW  = 7'b0000100;
    localparam logic [6:0] LD  = 7'b0001000;
    localparam logic [6:0] LBU = 7'b0010000;
    localparam logic [6:0] LHU = 7'b0100000;
    localparam logic [6:0] LWU = 7'b1000000;
    localparam logic [3:0] SB  = 4'b0001;
    localparam logic [3:0] SH  = 4'b0010;
    localparam logic [3:0] SW  = 4'b0100;
    localparam logic [3:0] SD  = 4'b1000;

    localparam logic [6:0]  LD_T [8] = '{LB, LBU, LH, LHU, LW, LWU, LD, LB};
    localparam logic [63:0] LD_A [8] = '{64'h8000_0003, 64'h8000_0003, 64'h1002, 64'h1002,
                                        64'h1004, 64'h1004, 64'h1008, 64'h1007};
    localparam logic [63:0] LD_R [8] = '{64'h0000_0000_80FF_0000, 64'h0000_0000_80FF_0000,
                                        64'h0000_0000_8001_0000, 64'h0000_0000_8001_0000,
                                        64'h9876_5432_0000_0000, 64'h9876_5432_0000_0000,
                                        64'h0123_4567_89AB_CDEF, 64'h7F00_0000_0000_0000};
    localparam logic [63:0] LD_E [8] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080,
                                        64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_0000_8001,
                                        64'hFFFF_FFFF_9876_5432, 64'h0000_0000_9876_5432,
                                        64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_007F};

    localparam logic [3:0]  ST_T [3] = '{SB, SW, SD};
    localparam logic [63:0] ST_A [3] = '{64'h3005, 64'h3004, 64'h3000};
    localparam logic [63:0] ST_D [3] = '{64'h1111_2222_3333_44EF, 64'hAAAA_BBBB_1234_5678,
                                        64'h0102_0304_0506_0708};
    localparam logic [7:0]  ST_S [3] = '{8'h20, 8'hF0, 8'hFF};
    localparam logic [63:0] ST_W [3] = '{64'hEFEF_EFEF_EFEF_EFEF, 64'h1234_5678_1234_5678,
                                        64'h0102_0304_0506_0708};

    logic            clk;
    logic            rst;
    logic            exe_to_mem_valid;
    logic            mem_allow_in;
    logic            mem_valid;
    logic            mem_to_wb_valid;
    logic            wb_allow_in;
    logic            clear_pipline;
    logic [63:0]     exe_pc;
    logic [31:0]     exe_inst;
    logic [4:0]      exe_rd;
    logic            exe_rd_wen;
    logic [63:0]     exe_result;
    logic [63:0]     exe_rs2_data;
    logic [6:0]      exe_ld_type;
    logic [3:0]      exe_st_type;
    logic [SB_W-1:0] exe_sideband;
    logic            dmem_req_valid;
    logic            dmem_req_ready;
    logic [AW-1:0]   dmem_addr;
    logic            dmem_wen;
    logic [7:0]      dmem_wstrb;
    logic [63:0]     dmem_wdata;
    logic            dmem_resp_valid;
    logic [63:0]     dmem_rdata;
    logic [63:0]     mem_pc;
    logic [31:0]     mem_inst;
    logic [4:0]      mem_rd;
    logic            mem_rd_wen;
    logic [SB_W-1:0] mem_sideband;
    logic [63:0]     mem_result;
    logic            mem_ex_misalign;

    int n_checks = 0;
    int n_fail   = 0;

    memu #(.SB_W(SB_W), .AW(AW)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .exe_to_mem_valid (exe_to_mem_valid),
        .mem_allow_in     (mem_allow_in),
        .mem_valid        (mem_valid),
        .mem_to_wb_valid  (mem_to_wb_valid),
        .wb_allow_in      (wb_allow_in),
        .clear_pipline    (clear_pipline),
        .exe_pc           (exe_pc),
        .exe_inst         (exe_inst),
        .exe_rd           (exe_rd),
        .exe_rd_wen       (exe_rd_wen),
        .exe_result       (exe_result),
        .exe_rs2_data     (exe_rs2_data),
        .exe_ld_type      (exe_ld_type),
        .exe_st_type      (exe_st_type),
        .exe_sideband     (exe_sideband),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_addr        (dmem_addr),
        .dmem_wen         (dmem_wen),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_wdata       (dmem_wdata),
        .dmem_resp_valid  (dmem_resp_valid),
        .dmem_rdata       (dmem_rdata),
        .mem_pc           (mem_pc),
        .mem_inst         (mem_inst),
        .mem_rd           (mem_rd),
        .mem_rd_wen       (mem_rd_wen),
        .mem_sideband     (mem_sideband),
        .mem_result       (mem_result),
        .mem_ex_misalign  (mem_ex_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Present one instruction for a single cycle; returns #1 after the following negedge.
    task automatic send(input logic [6:0] ld, input logic [3:0] st, input logic [63:0] res,
                        input logic [63:0] rs2);
        @(negedge clk);
        exe_to_mem_valid = 1'b1;
        exe_ld_type      = ld;
        exe_st_type      = st;
        exe_result       = res;
        exe_rs2_data     = rs2;
        @(negedge clk);
        exe_to_mem_valid = 1'b0;
        exe_ld_type      = '0;
        exe_st_type      = '0;
        #1;
    endtask

    // From REQ: accept at once, respond next cycle; returns #1 into DONE.
    task automatic complete(input logic [63:0] rdata);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_rdata      = rdata;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        dmem_rdata      = '0;
        #1;
    endtask

    task automatic to_done(input logic [6:0] ld, input logic [3:0] st, input logic [63:0] res,
                           input logic [63:0] rs2, input logic [63:0] rdata,
                           output logic seen, output logic [63:0] addr);
        send(ld, st, res, rs2);
        seen = dmem_req_valid;
        addr = dmem_addr;
        complete(rdata);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_mem_valid: got %0h required 0", mem_valid); end
        n_checks++; if (dmem_req_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_req_valid: got %0h required 0", dmem_req_valid); end
        n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_wb_valid: got %0h required 0", mem_to_wb_valid); end
        n_checks++; if (mem_allow_in !== 1'b1) begin n_fail++;
            $display("FAIL reset_allow_in: got %0h required 1", mem_allow_in); end
        n_checks++; if (mem_result !== 64'h0) begin n_fail++;
            $display("FAIL reset_result: got %h required 0", mem_result); end
        n_checks++; if (mem_ex_misalign !== 1'b0) begin n_fail++;
            $display("FAIL reset_misalign: got %0h required 0", mem_ex_misalign); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu();
        exe_pc       = 64'h8000_0100;
        exe_inst     = 32'h00B5_0533;
        exe_rd       = 5'd10;
        exe_rd_wen   = 1'b1;
        exe_sideband = {13'h1ABC, 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF};
        send(7'd0, 4'd0, 64'h1234, 64'h0);
        n_checks++; if (mem_to_wb_valid !== 1'b1) begin n_fail++;
            $display("FAIL alu_wb_valid: got %0h required 1", mem_to_wb_valid); end
        n_checks++; if (mem_result !== 64'h1234) begin n_fail++;
            $display("FAIL alu_result: got %h required 1234", mem_result); end
        n_checks++; if (dmem_req_valid !== 1'b0) begin n_fail++;
            $display("FAIL alu_no_req: got %0h required 0", dmem_req_valid); end
        n_checks++; if (mem_pc !== 64'h8000_0100 || mem_inst !== 32'h00B5_0533) begin n_fail++;
            $display("FAIL alu_pc_inst: got %h/%h required 80000100/00b50533", mem_pc, mem_inst);
        end
        n_checks++; if (mem_rd !== 5'd10 || mem_rd_wen !== 1'b1) begin n_fail++;
            $display("FAIL alu_rd: got %0d/%0h required 10/1", mem_rd, mem_rd_wen); end
        n_checks++;
        if (mem_sideband !== {13'h1ABC, 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF}) begin
            n_fail++; $display("FAIL alu_sideband: got %h", mem_sideband); end
        @(negedge clk);
        #1;
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++;
            $display("FAIL alu_retired: got %0h required 0", mem_valid); end
    endtask

    task automatic test_loads();
        logic        seen;
        logic [63:0] addr;
        for (int i = 0; i < 8; i++) begin
            to_done(LD_T[i], 4'd0, LD_A[i], 64'h0, LD_R[i], seen, addr);
            n_checks++; if (seen !== 1'b1 || addr !== {LD_A[i][63:3], 3'b000}) begin n_fail++;
                $display("FAIL load%0d_req: got valid %0h addr %h required 1 %h", i, seen, addr,
                         {LD_A[i][63:3], 3'b000}); end
            n_checks++; if (mem_to_wb_valid !== 1'b1 || mem_result !== LD_E[i]) begin n_fail++;
                $display("FAIL load%0d_result: got %0h %h required 1 %h", i, mem_to_wb_valid,
                         mem_result, LD_E[i]); end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_store_stall();
        send(7'd0, SH, 64'h2006, 64'h1111_2222_3333_ABCD);
        exe_to_mem_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (dmem_req_valid !== 1'b1 || dmem_addr !== 64'h2000) begin n_fail++;
                $display("FAIL sh_hold%0d_req: got %0h %h required 1 2000", i, dmem_req_valid,
                         dmem_addr); end
            n_checks++;
            if (dmem_wstrb !== 8'hC0 || dmem_wdata !== 64'hABCD_ABCD_ABCD_ABCD || dmem_wen !== 1'b1)
            begin n_fail++;
                $display("FAIL sh_hold%0d_data: got %h %h %0h required c0 abcdabcdabcdabcd 1", i,
                         dmem_wstrb, dmem_wdata, dmem_wen); end
            n_checks++; if (mem_allow_in !== 1'b0) begin n_fail++;
                $display("FAIL sh_hold%0d_allow_in: got %0h required 0", i, mem_allow_in); end
            @(negedge clk);
            #1;
        end
        exe_to_mem_valid = 1'b0;
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_rdata      = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL sh_wait_wb_valid: got %0h required 0", mem_to_wb_valid); end
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        wb_allow_in     = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (mem_to_wb_valid !== 1'b1 || mem_result !== 64'h2006) begin n_fail++;
                $display("FAIL sh_wb_stall%0d: got %0h %h required 1 2006", i, mem_to_wb_valid,
                         mem_result); end
            n_checks++; if (mem_allow_in !== 1'b0) begin n_fail++;
                $display("FAIL sh_wb_stall%0d_allow_in: got %0h required 0", i, mem_allow_in); end
            @(negedge clk);
            #1;
        end
        wb_allow_in = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++;
            $display("FAIL sh_retired: got %0h required 0", mem_valid); end
    endtask

    task automatic test_store_lanes();
        for (int i = 0; i < 3; i++) begin
            send(7'd0, ST_T[i], ST_A[i], ST_D[i]);
            n_checks++;
            if (dmem_req_valid !== 1'b1 || dmem_wstrb !== ST_S[i] || dmem_wdata !== ST_W[i]) begin
                n_fail++;
                $display("FAIL store%0d_lanes: got %0h %h %h required 1 %h %h", i, dmem_req_valid,
                         dmem_wstrb, dmem_wdata, ST_S[i], ST_W[i]); end
            complete(64'h0);
            n_checks++; if (mem_to_wb_valid !== 1'b1 || mem_result !== ST_A[i]) begin n_fail++;
                $display("FAIL store%0d_result: got %0h %h required 1 %h", i, mem_to_wb_valid,
                         mem_result, ST_A[i]); end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_flush();
        logic        seen;
        logic [63:0] addr;
        // Flush in REQ before the handshake.
        send(LD, 4'd0, 64'h5000, 64'h0);
        clear_pipline = 1'b1;
        @(negedge clk);
        clear_pipline = 1'b0;
        #1;
        n_checks++; if (dmem_req_valid !== 1'b0 || mem_valid !== 1'b0) begin n_fail++;
            $display("FAIL flush_req: got %0h %0h required 0 0", dmem_req_valid, mem_valid); end
        // Flush in WAIT: stale response must be swallowed.
        send(LD, 4'd0, 64'h5008, 64'h0);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        clear_pipline  = 1'b1;
        #1;
        n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL flush_wait_wb: got %0h required 0", mem_to_wb_valid); end
        @(negedge clk);
        clear_pipline = 1'b0;
        #1;
        n_checks++; if (mem_allow_in !== 1'b0 || mem_valid !== 1'b0) begin n_fail++;
            $display("FAIL flush_drain: got %0h %0h required 0 0", mem_allow_in, mem_valid); end
        dmem_resp_valid = 1'b1;
        dmem_rdata      = 64'hDEAD;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        #1;
        n_checks++; if (mem_to_wb_valid !== 1'b0 || mem_allow_in !== 1'b1) begin n_fail++;
            $display("FAIL flush_drained: got %0h %0h required 0 1", mem_to_wb_valid,
                     mem_allow_in); end
        to_done(LD, 4'd0, 64'h5010, 64'h0, 64'h1122_3344_5566_7788, seen, addr);
        n_checks++; if (mem_to_wb_valid !== 1'b1 || mem_result !== 64'h1122_3344_5566_7788)
        begin n_fail++;
            $display("FAIL flush_next_ld: got %0h %h required 1 1122334455667788",
                     mem_to_wb_valid, mem_result); end
        // Flush in DONE.
        clear_pipline = 1'b1;
        #1;
        n_checks++; if (mem_to_wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL flush_done_wb: got %0h required 0", mem_to_wb_valid); end
        @(negedge clk);
        clear_pipline = 1'b0;
        #1;
        n_checks++; if (mem_valid !== 1'b0 || dmem_req_valid !== 1'b0) begin n_fail++;
            $display("FAIL flush_done: got %0h %0h required 0 0", mem_valid, dmem_req_valid); end
        // Flush coinciding with the REQ handshake.
        send(7'd0, SD, 64'h5018, 64'h77);
        dmem_req_ready = 1'b1;
        clear_pipline  = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        clear_pipline  = 1'b0;
        #1;
        n_checks++; if (mem_allow_in !== 1'b0) begin n_fail++;
            $display("FAIL flush_hs_drain: got %0h required 0", mem_allow_in); end
        dmem_resp_valid = 1'b1;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        #1;
        n_checks++; if (mem_allow_in !== 1'b1 || mem_to_wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL flush_hs_idle: got %0h %0h required 1 0", mem_allow_in,
                     mem_to_wb_valid); end
    endtask

    task automatic test_back_to_back();
        logic        seen;
        logic [63:0] addr;
        to_done(LBU, 4'd0, 64'h8000_0003, 64'h0, 64'h0000_0000_80FF_0000, seen, addr);
        exe_to_mem_valid = 1'b1;
        exe_result       = 64'h55;
        #1;
        n_checks++; if (mem_allow_in !== 1'b1 || mem_to_wb_valid !== 1'b1 || mem_result !== 64'h80)
        begin n_fail++;
            $display("FAIL b2b_lbu: got %0h %0h %h required 1 1 80", mem_allow_in,
                     mem_to_wb_valid, mem_result); end
        @(negedge clk);
        exe_st_type  = SD;
        exe_result   = 64'h6000;
        exe_rs2_data = 64'hCAFE;
        #1;
        n_checks++; if (mem_to_wb_valid !== 1'b1 || mem_result !== 64'h55 || dmem_req_valid !== 1'b0)
        begin n_fail++;
            $display("FAIL b2b_add: got %0h %h %0h required 1 55 0", mem_to_wb_valid, mem_result,
                     dmem_req_valid); end
        @(negedge clk);
        exe_to_mem_valid = 1'b0;
        exe_st_type      = '0;
        #1;
        n_checks++; if (dmem_req_valid !== 1'b1 || dmem_addr !== 64'h6000 || dmem_wstrb !== 8'hFF)
        begin n_fail++;
            $display("FAIL b2b_sd_req: got %0h %h %h required 1 6000 ff", dmem_req_valid,
                     dmem_addr, dmem_wstrb); end
        complete(64'h0);
        exe_to_mem_valid = 1'b1;
        exe_ld_type      = LB;
        exe_result       = 64'h7001;
        @(negedge clk);
        exe_to_mem_valid = 1'b0;
        exe_ld_type      = '0;
        #1;
        n_checks++; if (dmem_req_valid !== 1'b1 || dmem_addr !== 64'h7000) begin n_fail++;
            $display("FAIL b2b_done_to_req: got %0h %h required 1 7000", dmem_req_valid,
                     dmem_addr); end
        complete(64'h0000_0000_0000_FF00);
        n_checks++; if (mem_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++;
            $display("FAIL b2b_lb_result: got %h required ffffffffffffffff", mem_result); end
        @(negedge clk);
        #1;
    endtask

    task automatic test_misalign();
`ifdef MEMU_MISALIGN_CHK_EN
        send(LW, 4'd0, 64'h4002, 64'h0);
        n_checks++; if (dmem_req_valid !== 1'b0 || mem_ex_misalign !== 1'b1) begin n_fail++;
            $display("FAIL misalign_trap: got %0h %0h required 0 1", dmem_req_valid,
                     mem_ex_misalign); end
        n_checks++; if (mem_to_wb_valid !== 1'b1 || mem_result !== 64'h4002) begin n_fail++;
            $display("FAIL misalign_result: got %0h %h required 1 4002", mem_to_wb_valid,
                     mem_result); end
        @(negedge clk);
        #1;
        send(7'd0, SW, 64'h3006, 64'h1234_5678);
        n_checks++; if (dmem_req_valid !== 1'b0 || mem_ex_misalign !== 1'b1) begin n_fail++;
            $display("FAIL misalign_sw: got %0h %0h required 0 1", dmem_req_valid,
                     mem_ex_misalign); end
        @(negedge clk);
        #1;
`else
        send(LW, 4'd0, 64'h4002, 64'h0);
        n_checks++; if (dmem_req_valid !== 1'b1 || dmem_addr !== 64'h4000 || dmem_wen !== 1'b0)
        begin n_fail++;
            $display("FAIL misalign_lw_req: got %0h %h %0h required 1 4000 0", dmem_req_valid,
                     dmem_addr, dmem_wen); end
        complete(64'h0000_1234_5678_0000);
        n_checks++; if (mem_result !== 64'h1234_5678 || mem_ex_misalign !== 1'b0) begin n_fail++;
            $display("FAIL misalign_lw_result: got %h %0h required 12345678 0", mem_result,
                     mem_ex_misalign); end
        @(negedge clk);
        #1;
        send(7'd0, SW, 64'h3006, 64'hAAAA_BBBB_1234_5678);
        n_checks++; if (dmem_wstrb !== 8'hC0 || dmem_wdata !== 64'h1234_5678_1234_5678) begin
            n_fail++;
            $display("FAIL misalign_sw_lanes: got %h %h required c0 1234567812345678",
                     dmem_wstrb, dmem_wdata); end
        complete(64'h0);
        @(negedge clk);
        #1;
`endif
    endtask

    initial begin
        rst              = 1'b1;
        exe_to_mem_valid = 1'b0;
        wb_allow_in      = 1'b1;
        clear_pipline    = 1'b0;
        exe_pc           = '0;
        exe_inst         = '0;
        exe_rd           = '0;
        exe_rd_wen       = 1'b0;
        exe_result       = '0;
        exe_rs2_data     = '0;
        exe_ld_type      = '0;
        exe_st_type      = '0;
        exe_sideband     = '0;
        dmem_req_ready   = 1'b0;
        dmem_resp_valid  = 1'b0;
        dmem_rdata       = '0;
        test_reset();
        test_alu();
        test_loads();
        test_store_stall();
        test_store_lanes();
        test_flush();
        test_back_to_back();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
